pong_match_ctrl: RTL and testbench

Match sequencer for the Pong datapath. It owns the game state (idle, serve countdown, rally, point pause, game over), keeps both scores and decides the winner. It drives `game_on` and `ball_reset` to the ball and paddle blocks, and sets the computer-paddle speed from the difficulty select. It sits between the button/difficulty inputs and the ball, paddle and computer-player instances, and runs on the pixel clock.

---
 rtl/pong_match_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - Pong match sequencer: game state, scores, winner and computer-paddle speed
//
// Owns the match flow IDLE -> SERVE -> PLAY -> POINT/OVER, keeps both scores,
// decides the winner and latches the computer-paddle speed from the difficulty
// select at each start. Runs on the pixel clock.
//
// Optional feature macro: PONG_WIN_BY_TWO_EN
//   defined   : win needs score >= WIN_SCORE and a lead of at least 2; a score
//               that would overflow saturates and that scorer wins at once.
//   undefined : win when the new score equals WIN_SCORE.
//
// Ports:
//   clk             in   pixel clock, rising edge
//   reset           in   asynchronous active-low reset
//   frame_tick      in   one-cycle pulse per video frame
//   start           in   one-cycle start pulse (debounced, edge-detected)
//   miss_left       in   pulse: ball passed the left paddle
//   miss_right      in   pulse: ball passed the right paddle
//   diff[1:0]       in   difficulty select
//   game_on         out  high only during a rally (decoded from state)
//   ball_reset      out  holds ball at centre whenever not in a rally
//   serve_dir       out  1 = next serve rightward, 0 = leftward
//   score_left      out  left player score
//   score_right     out  right player score
//   winner[1:0]     out  00 none, 01 left, 10 right
//   ai_ticks_per_px out  computer paddle speed setting
//   state[2:0]      out  IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic [1:0]         diff,
  output logic               game_on,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic [1:0]         winner,
  output logic [7:0]         ai_ticks_per_px,
  output logic [2:0]         state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [SCORE_W-1:0] score_left_n, score_right_n;
  logic [1:0]         winner_n;
  logic               serve_dir_n;
  logic [7:0]         ai_n;

  // Candidate post-point scores and the win decision for each side.
  logic [SCORE_W-1:0] left_next, right_next;
  logic               left_wins, right_wins;

`ifdef PONG_WIN_BY_TWO_EN
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W:0]   LEAD_MIN  = (SCORE_W+1)'(2);

  logic left_sat, right_sat;

  assign left_sat   = (score_left == SCORE_MAX);
  assign right_sat  = (score_right == SCORE_MAX);
  assign left_next  = left_sat ? score_left : score_left + 1'b1;
  assign right_next = right_sat ? score_right : score_right + 1'b1;
  // One extra bit so the lead test cannot wrap.
  assign left_wins  = left_sat ||
                      ((left_next >= WIN_VAL) && ({1'b0, left_next} >= {1'b0, score_right} + LEAD_MIN));
  assign right_wins = right_sat ||
                      ((right_next >= WIN_VAL) && ({1'b0, right_next} >= {1'b0, score_left} + LEAD_MIN));
`else
  assign left_next  = score_left + 1'b1;
  assign right_next = score_right + 1'b1;
  assign left_wins  = (left_next == WIN_VAL);
  assign right_wins = (right_next == WIN_VAL);
`endif

  function automatic logic [7:0] speed_of(input logic [1:0] d);
    case (d)
      2'b00:   speed_of = 8'd8;
      2'b01:   speed_of = 8'd6;
      2'b10:   speed_of = 8'd4;
      default: speed_of = 8'd2;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      score_left      <= '0;
      score_right     <= '0;
      winner          <= 2'b00;
      serve_dir       <= 1'b1;
      ai_ticks_per_px <= 8'd8;
    end else begin
      state_q         <= state_n;
      cnt_q           <= cnt_n;
      score_left      <= score_left_n;
      score_right     <= score_right_n;
      winner          <= winner_n;
      serve_dir       <= serve_dir_n;
      ai_ticks_per_px <= ai_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    cnt_n         = cnt_q;
    score_left_n  = score_left;
    score_right_n = score_right;
    winner_n      = winner;
    serve_dir_n   = serve_dir;
    ai_n          = ai_ticks_per_px;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          score_left_n  = '0;
          score_right_n = '0;
          winner_n      = 2'b00;
          ai_n          = speed_of(diff);
          serve_dir_n   = 1'b1;
          cnt_n         = SERVE_LOAD;
          state_n       = ST_SERVE;
        end
      end

      ST_SERVE, ST_POINT: begin
        if (frame_tick) begin
          // <=1 rather than ==1 so a stray zero count can never stall here.
          if (cnt_q <= CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = ST_PLAY;
          end else begin
            cnt_n = cnt_q - 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (miss_left && miss_right) begin
          cnt_n   = POINT_LOAD;
          state_n = ST_POINT;
        end else if (miss_left) begin
          score_right_n = right_next;
          serve_dir_n   = 1'b0;
          if (right_wins) begin
            winner_n = 2'b10;
            state_n  = ST_OVER;
          end else begin
            cnt_n   = POINT_LOAD;
            state_n = ST_POINT;
          end
        end else if (miss_right) begin
          score_left_n = left_next;
          serve_dir_n  = 1'b1;
          if (left_wins) begin
            winner_n = 2'b01;
            state_n  = ST_OVER;
          end else begin
            cnt_n   = POINT_LOAD;
            state_n = ST_POINT;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign state      = state_q;
  assign game_on    = (state_q == ST_PLAY);
  assign ball_reset = (state_q != ST_PLAY);

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb/tb_pong_match_ctrl.sv - table-driven scoreboard bench for pong_match_ctrl
module tb_pong_match_ctrl;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick, start, miss_left, miss_right;
  logic [1:0] diff;
  logic       game_on, ball_reset, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [7:0] ai_ticks_per_px;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  pong_match_ctrl #(
    .WIN_SCORE   (3),
    .SCORE_W     (4),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_tick     (frame_tick),
    .start          (start),
    .miss_left      (miss_left),
    .miss_right     (miss_right),
    .diff           (diff),
    .game_on        (game_on),
    .ball_reset     (ball_reset),
    .serve_dir      (serve_dir),
    .score_left     (score_left),
    .score_right    (score_right),
    .winner         (winner),
    .ai_ticks_per_px(ai_ticks_per_px),
    .state          (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, tk, ml, mr;
    logic [1:0] df;
    int         s, sl, sr, w, dir, ai;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic void add(input logic st, tk, ml, mr, input logic [1:0] df,
                              input int s, sl, sr, w, dir, ai);
    vec_t v;
    v.st = st; v.tk = tk; v.ml = ml; v.mr = mr; v.df = df;
    v.s = s; v.sl = sl; v.sr = sr; v.w = w; v.dir = dir; v.ai = ai;
    tbl.push_back(v);
  endfunction

  // Three ticks through a point pause: two stay in POINT, the third enters PLAY.
  function automatic void point_wait(input int sl, sr, dir, ai);
    add(0, 1, 0, 0, 2'b11, S_POINT, sl, sr, 0, dir, ai);
    add(0, 1, 0, 0, 2'b11, S_POINT, sl, sr, 0, dir, ai);
    add(0, 1, 0, 0, 2'b11, S_PLAY,  sl, sr, 0, dir, ai);
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, " state"},      int'(state), S_IDLE);
    chk({tag, " score_left"}, int'(score_left), 0);
    chk({tag, " score_right"},int'(score_right), 0);
    chk({tag, " winner"},     int'(winner), 0);
    chk({tag, " serve_dir"},  int'(serve_dir), 1);
    chk({tag, " ai"},         int'(ai_ticks_per_px), 8);
    chk({tag, " game_on"},    int'(game_on), 0);
    chk({tag, " ball_reset"}, int'(ball_reset), 1);
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    string t;
    @(negedge clk);
    start = v.st; frame_tick = v.tk; miss_left = v.ml; miss_right = v.mr; diff = v.df;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = $sformatf("row%0d", idx);
    chk({t, " state"},       int'(state), e.s);
    chk({t, " score_left"},  int'(score_left), e.sl);
    chk({t, " score_right"}, int'(score_right), e.sr);
    chk({t, " winner"},      int'(winner), e.w);
    chk({t, " serve_dir"},   int'(serve_dir), e.dir);
    chk({t, " ai"},          int'(ai_ticks_per_px), e.ai);
    chk({t, " game_on"},     int'(game_on), (e.s == S_PLAY) ? 1 : 0);
    chk({t, " ball_reset"},  int'(ball_reset), (e.s == S_PLAY) ? 0 : 1);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    reset = 1'b0; start = 0; frame_tick = 0; miss_left = 0; miss_right = 0; diff = 2'b00;

    //  st tk ml mr diff   state    sl sr w dir ai
    add(1, 1, 0, 0, 2'b10, S_SERVE, 0, 0, 0, 1, 4);  // coincident tick not counted
    add(0, 1, 0, 0, 2'b10, S_SERVE, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 2'b11, S_SERVE, 0, 0, 0, 1, 4);  // diff change ignored
    add(0, 1, 0, 0, 2'b11, S_PLAY,  0, 0, 0, 1, 4);
    add(1, 0, 0, 0, 2'b00, S_PLAY,  0, 0, 0, 1, 4);  // start ignored in PLAY
    add(0, 0, 1, 0, 2'b00, S_POINT, 0, 1, 0, 0, 4);
    add(0, 0, 1, 0, 2'b00, S_POINT, 0, 1, 0, 0, 4);  // miss ignored in POINT
    point_wait(0, 1, 0, 4);
    add(0, 0, 1, 1, 2'b00, S_POINT, 0, 1, 0, 0, 4);  // double miss
    point_wait(0, 1, 0, 4);
    add(0, 0, 0, 1, 2'b00, S_POINT, 1, 1, 0, 1, 4);
    point_wait(1, 1, 1, 4);
    add(0, 0, 0, 1, 2'b00, S_POINT, 2, 1, 0, 1, 4);
    point_wait(2, 1, 1, 4);
`ifdef PONG_WIN_BY_TWO_EN
    add(0, 0, 1, 0, 2'b00, S_POINT, 2, 2, 0, 0, 4);
    point_wait(2, 2, 0, 4);
    add(0, 0, 1, 0, 2'b00, S_POINT, 2, 3, 0, 0, 4);  // 3 points but lead of 1
    point_wait(2, 3, 0, 4);
    add(0, 0, 0, 1, 2'b00, S_POINT, 3, 3, 0, 1, 4);
    point_wait(3, 3, 1, 4);
    add(0, 0, 0, 1, 2'b00, S_POINT, 4, 3, 0, 1, 4);
    point_wait(4, 3, 1, 4);
    add(0, 0, 0, 1, 2'b00, S_OVER,  5, 3, 1, 1, 4);
    add(0, 0, 1, 0, 2'b00, S_OVER,  5, 3, 1, 1, 4);  // miss ignored in OVER
`else
    add(0, 0, 0, 1, 2'b00, S_OVER,  3, 1, 1, 1, 4);
    add(0, 0, 1, 0, 2'b00, S_OVER,  3, 1, 1, 1, 4);  // miss ignored in OVER
`endif
    add(0, 1, 0, 0, 2'b00, S_OVER,  tbl[tbl.size()-1].sl, tbl[tbl.size()-1].sr, 1, 1, 4);
    add(1, 0, 0, 0, 2'b00, S_SERVE, 0, 0, 0, 1, 8);  // restart clears and relatches
    add(0, 1, 0, 0, 2'b00, S_SERVE, 0, 0, 0, 1, 8);
    add(0, 1, 0, 0, 2'b00, S_PLAY,  0, 0, 0, 1, 8);
    add(0, 0, 1, 0, 2'b00, S_POINT, 0, 1, 0, 0, 8);

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    run_table();

    // Asynchronous reset mid-POINT, checked before any clock edge.
    @(negedge clk);
    start = 0; frame_tick = 0; miss_left = 0; miss_right = 0;
    #2 reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;

    add(1, 0, 0, 0, 2'b01, S_SERVE, 0, 0, 0, 1, 6);
    add(0, 1, 0, 0, 2'b01, S_SERVE, 0, 0, 0, 1, 6);
    add(0, 1, 0, 0, 2'b01, S_PLAY,  0, 0, 0, 1, 6);
    add(1, 0, 0, 0, 2'b11, S_PLAY,  0, 0, 0, 1, 6);  // start ignored in PLAY
    add(0, 0, 0, 1, 2'b11, S_POINT, 1, 0, 0, 1, 6);
    run_table();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
